mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised pipeline-boundary register that generalises the Mem→WB latch into a ready/valid stage with flush and an optional skid entry. It carries a control field, which is forced to zero on bubbles so RegWrite/MemtoReg never fire spuriously, and a data field, which is held rather than cleared. It is placed between any two pipeline stages (EX/Mem, Mem/WB) and supports stalls without a combinational ready path back through the pipe.

## Interface
Parameters:
- CTRL_W, 2, control-bit width; e.g. {MemtoReg, RegWrite}
- DATA_W, 133, data-field width; e.g. {Read_Data[63:0], ALU_Result[63:0], rd[4:0]}
- SKID, 1, 1 = two-entry stage with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts the entry this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream data bits
- flush  in  1  synchronous kill of all held entries and of any entry offered this cycle
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream consumes the entry this cycle
- out_ctrl  out  CTRL_W  control of the head entry; all zero whenever out_valid=0
- out_data  out  DATA_W  data of the head entry; holds its last value when out_valid=0
- occupancy  out  2  number of held entries, 0..2 (never exceeds 1 when SKID=0)

## Operation
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Storage: main entry {m_v, m_ctrl, m_data} drives the outputs. The skid entry {s_v, s_ctrl, s_data} exists only when SKID=1.
- States for SKID=1: EMPTY (m_v=0), ONE (m_v=1, s_v=0), TWO (m_v=1, s_v=1). occupancy = 0/1/2 respectively.
- in_ready for SKID=1 = ~s_v. It is purely registered and has no path from out_ready.
- SKID=1 transitions, evaluated when flush=0:
  - EMPTY: accept → ONE, main ← input.
  - ONE, consume & accept: stay in ONE, main ← input.
  - ONE, consume & ~accept: → EMPTY.
  - ONE, ~consume & accept: → TWO, skid ← input.
  - ONE, ~consume & ~accept: hold.
  - TWO (in_ready=0): consume → ONE, main ← skid. Otherwise hold.
- SKID=0: in_ready = ~m_v | out_ready (combinational). Main ← input on accept; m_v ← accept | (m_v & ~out_ready).
- flush=1 has priority over everything. Next state is EMPTY with m_v=s_v=0. Any entry accepted or consumed that cycle is discarded. Data registers keep their values.
- out_ctrl = m_v ? m_ctrl : 0. The output gating makes this hold even if m_ctrl is stale.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- reset: m_v, s_v, m_ctrl, s_ctrl, m_data, s_data all ← 0, so every output is 0 asynchronously. in_ready = 1 during and after reset in both modes (SKID=0: ~m_v=1).

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N and is consumable in cycle N+1. This gives one cycle, identical to the legacy latch.
- Throughput: one entry per cycle while out_ready=1, for both SKID values.
- SKID=1 absorbs exactly one extra entry after out_ready drops. in_ready falls one cycle later (registered).
- Data changes only on an accept or a skid→main move. Data is never changed by flush or by a bubble.
- Flush asserted in cycle N gives out_valid=0 and in_ready=1 in cycle N+1.
- Reset asserted mid-operation clears state without waiting for a clock edge. The first accept after deassertion occurs at the first rising edge with reset=0.
- Simultaneous consume and accept in state ONE never passes through EMPTY, so there is no bubble.

## Test plan
- Reset mid-stream: SKID=1, ctrl=2'b11, data=A in ONE. Pulse reset between edges → out_valid=0, out_ctrl=0, out_data=0, occupancy=0 immediately, and in_ready=1.
- Streaming: out_ready=1, feed D1..D8 back-to-back → D1..D8 on out_data in cycles 2..9, with no bubbles and occupancy ≤1.
- Backpressure (SKID=1):
  - Hold out_ready=0 while feeding D1, D2, D3 → occupancy reaches 2. in_ready=0 from the cycle after D2 is accepted. D3 is held upstream.
  - Release out_ready → D1, D2, D3 emerge in order, one per cycle.
- Flush in TWO: flush=1 with in_valid=1 (D9) → next cycle occupancy=0, out_valid=0, out_ctrl=0, and out_data unchanged. D9 never appears.
- Bubble gating: accept ctrl=2'b11 data=X, then consume it with no new input → out_valid=0, out_ctrl=2'b00, out_data=X.
- SKID=0 stall: out_ready=0 with m_v=1 → in_ready=0 in the same cycle. Set out_ready=1 and in_valid=1 in the same cycle → in_ready=1, and the replacement entry appears next cycle with no gap.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// Ready/valid pipeline-boundary register with flush and an optional skid entry.
// Control bits are gated to zero on bubbles; data bits hold their last value.
module mem_wb_pipe_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 133,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_v;
  logic              s_v;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              accept;
  logic              consume;

  assign accept    = in_valid & in_ready;
  assign consume   = m_v & out_ready;
  assign out_valid = m_v;
  // Gate on m_v so a stale m_ctrl can never raise RegWrite/MemtoReg on a bubble.
  assign out_ctrl  = m_v ? m_ctrl : '0;
  assign out_data  = m_data;

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      // in_ready comes straight from a flop: no path from out_ready.
      assign in_ready  = ~s_v;
      assign occupancy = s_v ? 2'd2 : (m_v ? 2'd1 : 2'd0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_v    <= 1'b0;
          s_v    <= 1'b0;
          m_ctrl <= '0;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
        end else if (!m_v) begin
          if (accept) begin
            m_v    <= 1'b1;
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end
        end else if (!s_v) begin
          if (consume && accept) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (consume) begin
            m_v <= 1'b0;
          end else if (accept) begin
            s_v    <= 1'b1;
            s_ctrl <= in_ctrl;
            s_data <= in_data;
          end
        end else if (consume) begin
          s_v    <= 1'b0;
          m_ctrl <= s_ctrl;
          m_data <= s_data;
        end
      end
    end else begin : g_noskid
      assign s_v       = 1'b0;
      assign in_ready  = ~m_v | out_ready;
      assign occupancy = {1'b0, m_v};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          m_v    <= 1'b0;
          m_ctrl <= '0;
          m_data <= '0;
        end else begin
          m_v <= ~flush & (accept | (m_v & ~out_ready));
          if (accept && !flush) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: SKID=1 and SKID=0 instances share one stimulus,
// each checked every cycle against a queue model plus directed literal checks.
module tb_mem_wb_pipe_reg;
  localparam int CW = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int checks = 0;
  int errors = 0;

  mem_wb_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
  );

  mem_wb_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of {ctrl,data}, capacity 2 or 1.
  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];
  logic [DW-1:0]    last1 = '0;
  logic [DW-1:0]    last0 = '0;
  bit               acc1, con1, acc0, con0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q1.delete();
      q0.delete();
      last1 = '0;
      last0 = '0;
    end else begin
      acc1 = in_valid && (q1.size() < 2);
      con1 = (q1.size() > 0) && out_ready;
      acc0 = in_valid && ((q0.size() == 0) || out_ready);
      con0 = (q0.size() > 0) && out_ready;
      if (flush) q1.delete();
      else begin
        if (con1) void'(q1.pop_front());
        if (acc1) q1.push_back({in_ctrl, in_data});
        if (q1.size() > 0) last1 = q1[0][DW-1:0];
      end
      if (flush) q0.delete();
      else begin
        if (con0) void'(q0.pop_front());
        if (acc0) q0.push_back({in_ctrl, in_data});
        if (q0.size() > 0) last0 = q0[0][DW-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("s1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
      chk("s1_out_ctrl", 32'(out_ctrl1), (q1.size() > 0) ? 32'(q1[0][CW+DW-1:DW]) : 32'd0);
      chk("s1_out_data", 32'(out_data1), (q1.size() > 0) ? 32'(q1[0][DW-1:0]) : 32'(last1));
      chk("s1_occupancy", 32'(occ1), 32'(q1.size()));
      chk("s1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
      chk("s0_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
      chk("s0_out_ctrl", 32'(out_ctrl0), (q0.size() > 0) ? 32'(q0[0][CW+DW-1:DW]) : 32'd0);
      chk("s0_out_data", 32'(out_data0), (q0.size() > 0) ? 32'(q0[0][DW-1:0]) : 32'(last0));
      chk("s0_occupancy", 32'(occ0), 32'(q0.size()));
      chk("s0_in_ready", 32'(in_ready0), 32'((q0.size() == 0) || out_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    #2;
    chk("reset_out_valid", 32'(out_valid1), 32'd0);
    chk("reset_in_ready1", 32'(in_ready1), 32'd1);
    chk("reset_in_ready0", 32'(in_ready0), 32'd1);
    chk("reset_occ", 32'(occ1), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset pulse between edges with an entry held
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'hA5A5);
    tick();
    drive(1'b0, 2'b00, 16'h0000);
    chk("pre_reset_valid", 32'(out_valid1), 32'd1);
    chk("pre_reset_data", 32'(out_data1), 32'hA5A5);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid1), 32'd0);
    chk("async_out_ctrl", 32'(out_ctrl1), 32'd0);
    chk("async_out_data", 32'(out_data1), 32'd0);
    chk("async_occ", 32'(occ1), 32'd0);
    chk("async_in_ready", 32'(in_ready1), 32'd1);
    chk("async_s0_data", 32'(out_data0), 32'd0);
    #1 reset = 1'b0;
    tick();

    // Back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, (i % 2 == 1) ? 2'b11 : 2'b10, 16'hD000 + 16'(i));
      tick();
      chk("stream_data", 32'(out_data1), 32'hD000 + 32'(i));
      chk("stream_occ", 32'(occ1), 32'd1);
      chk("stream_s0_data", 32'(out_data0), 32'hD000 + 32'(i));
    end
    drive(1'b0, 2'b00, 16'h0000);
    tick();
    chk("stream_end_valid", 32'(out_valid1), 32'd0);
    chk("stream_end_data", 32'(out_data1), 32'hD008);

    // Bubble gating
    drive(1'b1, 2'b11, 16'hABCD);
    tick();
    drive(1'b0, 2'b00, 16'h0000);
    chk("bubble_ctrl_live", 32'(out_ctrl1), 32'd3);
    tick();
    chk("bubble_valid", 32'(out_valid1), 32'd0);
    chk("bubble_ctrl", 32'(out_ctrl1), 32'd0);
    chk("bubble_data", 32'(out_data1), 32'hABCD);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'hB001);
    tick();
    drive(1'b1, 2'b10, 16'hB002);
    tick();
    chk("bp_occ2", 32'(occ1), 32'd2);
    chk("bp_in_ready", 32'(in_ready1), 32'd0);
    chk("s0_stall_in_ready", 32'(in_ready0), 32'd0);
    drive(1'b1, 2'b01, 16'hB003);
    tick();
    chk("bp_hold_occ", 32'(occ1), 32'd2);
    chk("bp_hold_data", 32'(out_data1), 32'hB001);
    out_ready = 1'b1;
    #1;
    chk("s0_release_in_ready", 32'(in_ready0), 32'd1);
    tick();
    chk("bp_rel1", 32'(out_data1), 32'hB002);
    chk("bp_rel1_occ", 32'(occ1), 32'd1);
    chk("s0_replace_valid", 32'(out_valid0), 32'd1);
    chk("s0_replace_data", 32'(out_data0), 32'hB003);
    tick();
    drive(1'b0, 2'b00, 16'h0000);
    chk("bp_rel2", 32'(out_data1), 32'hB003);
    chk("bp_rel2_ctrl", 32'(out_ctrl1), 32'd1);
    tick();

    // Flush while full, with an entry offered
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'hF001);
    tick();
    drive(1'b1, 2'b11, 16'hF002);
    tick();
    drive(1'b1, 2'b11, 16'h0D09);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0000);
    chk("flush_occ", 32'(occ1), 32'd0);
    chk("flush_valid", 32'(out_valid1), 32'd0);
    chk("flush_ctrl", 32'(out_ctrl1), 32'd0);
    chk("flush_data", 32'(out_data1), 32'hF001);
    chk("flush_in_ready", 32'(in_ready1), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 60; i++) begin
      drive((i % 3) != 0, CW'(i), 16'h5000 + 16'(i));
      out_ready = (i % 5) < 3;
      flush = (i == 37);
      tick();
    end
    drive(1'b0, 2'b00, 16'h0000);
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
